v_line_sw: RTL and testbench
============================

Name: v_line_sw

Overview:
- Parametrised successor to the vertical-line routing block of the multi-project grid.
- Muxes the west/east pad outputs and output enables of NMACROS stacked macros onto one column, and fans out the pad inputs.
- The select is a Wishbone-programmable register, not a static strap.
- A source change goes through a blanking state machine, so pads never see a glitch or two drivers; mux outputs are registered.

Parameters:
- NMACROS, 3, number of macros on the vertical line (2..8)
- EW_W, 14, width of each east/west pad bus
- SEL_W, 3, select field width; must satisfy 2**SEL_W >= NMACROS
- BASE_ADR, 32'h3000_0000, Wishbone address of CTRL; STATUS is at BASE_ADR+4
- BLANK_CYC, 4, cycles outputs are forced to 0 during a switch (>=1)

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  asynchronous active-high reset
- wbs_stb_i  in  1  WB strobe
- wbs_cyc_i  in  1  WB cycle
- wbs_we_i  in  1  WB write enable
- wbs_sel_i  in  4  WB byte selects
- wbs_adr_i  in  32  WB address
- wbs_dat_i  in  32  WB write data
- wbs_ack_o  out  1  WB acknowledge
- wbs_dat_o  out  32  WB read data
- west_o  in  NMACROS*EW_W  packed west outputs, macro k at [k*EW_W +: EW_W]
- west_oe  in  NMACROS*EW_W  packed west output enables
- east_o  in  NMACROS*EW_W  packed east outputs
- east_oe  in  NMACROS*EW_W  packed east output enables
- west_o_selected  out  EW_W  registered selected west output
- west_oe_selected  out  EW_W  registered selected west oe
- east_o_selected  out  EW_W  registered selected east output
- east_oe_selected  out  EW_W  registered selected east oe
- west_i  in  EW_W  west pad inputs
- east_i  in  EW_W  east pad inputs
- west_i_buf  out  NMACROS*EW_W  west_i replicated per macro, combinational
- east_i_buf  out  NMACROS*EW_W  east_i replicated per macro, combinational

Behaviour:
Registers:
- CTRL [SEL_W-1:0] pend_sel, [31] pend_en; reset 0, 0.
- STATUS (read-only) [SEL_W-1:0] act_sel, [8] busy, [9] err.
- Writing STATUS with dat[9]=1 and sel[1]=1 clears err.
- CTRL write: wbs_sel_i[0] gates pend_sel; wbs_sel_i[3] gates pend_en.
- pend_sel write value >= NMACROS: sel field ignored, err set (sticky); en field still applied.

Wishbone:
- ack asserts 1 cycle after stb&cyc&&address match, for exactly 1 cycle, then low for at least 1 cycle.
- Unmatched addresses are never acked.
- dat_o is valid only while ack=1, else 0; unused bits read 0.

FSM:
- OFF: outputs 0, busy=0.
- BLANK: outputs 0, busy=1, counter runs BLANK_CYC cycles.
- ACTIVE: outputs follow the mux, busy=0.
- Reset state is OFF, with act_sel=0, act_en=0.
- Any CTRL write that changes {pend_en, pend_sel} vs {act_en, act_sel} -> BLANK, counter=BLANK_CYC-1.
- A write that changes nothing causes no transition.
- BLANK, counter==0: act_sel<=pend_sel, act_en<=pend_en; -> ACTIVE if act_en, else OFF.
- Changing write during BLANK: counter reloads, pending config is the latest write.

Datapath:
- In ACTIVE, each *_selected output registers slice act_sel of its input bus; 1-cycle latency from input change.
- In OFF/BLANK, outputs register 0, so both o and oe=0 (pads tristated).
- First nonzero output appears the cycle after the BLANK->ACTIVE transition.

Reset:
- wb_rst_i asynchronously clears all registers, outputs, ack and err, including mid-BLANK and mid-ack.

Optional Feature:
- Macro V_LINE_SW_LOCK_EN.
- Defined:
  - CTRL[30] is a lock bit, write-1-only, cleared only by reset, readable at STATUS[10].
  - While lock=1, CTRL writes are acked but ignored and set err.
  - A write setting lock applies its sel/en fields in the same write.
- Undefined: CTRL[30] and STATUS[10] read 0; writes are never blocked.

Test Plan:
- Reset, then read STATUS -> ack 1 cycle after strobe, dat_o=0; all *_selected=0.
- Write CTRL=32'h8000_0001, sel=4'hF; west_o macro1=14'h1ABC.
  - busy=1 for 4 cycles, outputs 0.
  - west_o_selected=14'h1ABC from the cycle after ACTIVE; STATUS act_sel=1.
- In ACTIVE sel=1, write CTRL=32'h8000_0002, then write 32'h8000_0000 two cycles later.
  - Counter reloads; outputs 0 for 6 cycles total.
  - act_sel=0; macro1 never drives after the first write.
- Write CTRL sel=5 with NMACROS=3, en=1 -> sel field ignored, err=1, act_sel unchanged.
  - Write STATUS dat=32'h200, sel=4'h2 -> err=0.
- Assert wb_rst_i mid-BLANK and during an ack cycle -> all outputs and ack 0 immediately; state OFF after release.
- With V_LINE_SW_LOCK_EN: write 32'hC000_0002, then 32'h8000_0000.
  - act_sel stays 2; second write acked; err=1; STATUS[10]=1.

Source files
------------

// File: rtl/v_line_sw.sv
// Vertical-line pad switch: muxes NMACROS stacked macros onto one pad column under Wishbone control.
// Optional CTRL lock bit is compiled in when V_LINE_SW_LOCK_EN is defined.
module v_line_sw #(
   parameter int          NMACROS   = 3,
   parameter int          EW_W      = 14,
   parameter int          SEL_W     = 3,
   parameter logic [31:0] BASE_ADR  = 32'h3000_0000,
   parameter int          BLANK_CYC = 4
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   input  logic                    wbs_stb_i,
   input  logic                    wbs_cyc_i,
   input  logic                    wbs_we_i,
   input  logic [3:0]              wbs_sel_i,
   input  logic [31:0]             wbs_adr_i,
   input  logic [31:0]             wbs_dat_i,
   output logic                    wbs_ack_o,
   output logic [31:0]             wbs_dat_o,
   input  logic [NMACROS*EW_W-1:0] west_o,
   input  logic [NMACROS*EW_W-1:0] west_oe,
   input  logic [NMACROS*EW_W-1:0] east_o,
   input  logic [NMACROS*EW_W-1:0] east_oe,
   output logic [EW_W-1:0]         west_o_selected,
   output logic [EW_W-1:0]         west_oe_selected,
   output logic [EW_W-1:0]         east_o_selected,
   output logic [EW_W-1:0]         east_oe_selected,
   input  logic [EW_W-1:0]         west_i,
   input  logic [EW_W-1:0]         east_i,
   output logic [NMACROS*EW_W-1:0] west_i_buf,
   output logic [NMACROS*EW_W-1:0] east_i_buf
);

   localparam int              CNT_W    = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_CYC - 1);
   localparam logic [SEL_W:0]  NMAC     = (SEL_W + 1)'(NMACROS);
   localparam logic [31:0]     STAT_ADR = BASE_ADR + 32'd4;

   typedef enum logic [1:0] {
      S_OFF,
      S_BLANK,
      S_ACTIVE
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [SEL_W-1:0]  pend_sel, nxt_pend_sel, act_sel;
   logic              pend_en, nxt_pend_en, act_en;
   logic              err, lock;
   logic              adr_ctrl, adr_stat, req;
   logic              ctrl_wr, stat_wr, rd;
   logic              ctrl_apply, sel_bad, cfg_change, act_load;
   logic              err_set, err_clr;
   logic [31:0]       rd_data;
   logic [EW_W-1:0]   mux_w, mux_woe, mux_e, mux_eoe;
   logic              unused_wb;

   assign unused_wb = ^{wbs_sel_i, wbs_dat_i};

   assign west_i_buf = {NMACROS{west_i}};
   assign east_i_buf = {NMACROS{east_i}};

   // Gating req with ack guarantees at least one idle cycle between acks.
   assign adr_ctrl = (wbs_adr_i == BASE_ADR);
   assign adr_stat = (wbs_adr_i == STAT_ADR);
   assign req      = wbs_stb_i & wbs_cyc_i & (adr_ctrl | adr_stat) & ~wbs_ack_o;
   assign ctrl_wr  = req & wbs_we_i & adr_ctrl;
   assign stat_wr  = req & wbs_we_i & adr_stat;
   assign rd       = req & ~wbs_we_i;

`ifdef V_LINE_SW_LOCK_EN
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i)
         lock <= 1'b0;
      else if (ctrl_wr && wbs_sel_i[3] && wbs_dat_i[30])
         lock <= 1'b1;
   end
`else
   assign lock = 1'b0;
`endif

   // The write that sets lock still sees lock=0 here, so its fields apply.
   always_comb begin
      ctrl_apply   = ctrl_wr & ~lock;
      sel_bad      = ctrl_apply & wbs_sel_i[0] & ({1'b0, wbs_dat_i[SEL_W-1:0]} >= NMAC);
      nxt_pend_sel = pend_sel;
      nxt_pend_en  = pend_en;
      if (ctrl_apply && wbs_sel_i[0] && !sel_bad)
         nxt_pend_sel = wbs_dat_i[SEL_W-1:0];
      if (ctrl_apply && wbs_sel_i[3])
         nxt_pend_en = wbs_dat_i[31];
      cfg_change = ctrl_apply & ({nxt_pend_en, nxt_pend_sel} != {act_en, act_sel});
      err_set    = sel_bad | (ctrl_wr & lock);
      err_clr    = stat_wr & wbs_sel_i[1] & wbs_dat_i[9];
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         pend_sel <= '0;
         pend_en  <= 1'b0;
         err      <= 1'b0;
      end else begin
         pend_sel <= nxt_pend_sel;
         pend_en  <= nxt_pend_en;
         if (err_set)
            err <= 1'b1;
         else if (err_clr)
            err <= 1'b0;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      act_load  = 1'b0;
      if (cfg_change) begin
         state_nxt = S_BLANK;
         cnt_nxt   = CNT_LOAD;
      end else if (state == S_BLANK) begin
         if (cnt == '0) begin
            act_load  = 1'b1;
            state_nxt = nxt_pend_en ? S_ACTIVE : S_OFF;
         end else begin
            cnt_nxt = cnt - 1'b1;
         end
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state   <= S_OFF;
         cnt     <= '0;
         act_sel <= '0;
         act_en  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (act_load) begin
            act_sel <= nxt_pend_sel;
            act_en  <= nxt_pend_en;
         end
      end
   end

   always_comb begin
      mux_w   = '0;
      mux_woe = '0;
      mux_e   = '0;
      mux_eoe = '0;
      for (int unsigned k = 0; k < NMACROS; k++) begin
         if (act_sel == SEL_W'(k)) begin
            mux_w   = west_o [k*EW_W +: EW_W];
            mux_woe = west_oe[k*EW_W +: EW_W];
            mux_e   = east_o [k*EW_W +: EW_W];
            mux_eoe = east_oe[k*EW_W +: EW_W];
         end
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         west_o_selected  <= '0;
         west_oe_selected <= '0;
         east_o_selected  <= '0;
         east_oe_selected <= '0;
      end else if (state == S_ACTIVE) begin
         west_o_selected  <= mux_w;
         west_oe_selected <= mux_woe;
         east_o_selected  <= mux_e;
         east_oe_selected <= mux_eoe;
      end else begin
         west_o_selected  <= '0;
         west_oe_selected <= '0;
         east_o_selected  <= '0;
         east_oe_selected <= '0;
      end
   end

   always_comb begin
      rd_data = '0;
      if (adr_ctrl) begin
         rd_data[SEL_W-1:0] = pend_sel;
         rd_data[30]        = lock;
         rd_data[31]        = pend_en;
      end else begin
         rd_data[SEL_W-1:0] = act_sel;
         rd_data[8]         = (state == S_BLANK);
         rd_data[9]         = err;
         rd_data[10]        = lock;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
      end else begin
         wbs_ack_o <= req;
         wbs_dat_o <= rd ? rd_data : '0;
      end
   end

endmodule

// File: tb/tb_v_line_sw.sv
// Directed self-checking bench for v_line_sw (NMACROS=3, EW_W=14, BLANK_CYC=4).
// Lock-specific expectations follow V_LINE_SW_LOCK_EN.
module tb_v_line_sw;

   localparam int          NM   = 3;
   localparam int          EW   = 14;
   localparam logic [31:0] CTRL = 32'h3000_0000;
   localparam logic [31:0] STAT = 32'h3000_0004;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              stb = 1'b0, cyc = 1'b0, we = 1'b0;
   logic [3:0]        sel = '0;
   logic [31:0]       adr = '0, dat = '0;
   logic              ack;
   logic [31:0]       dat_o;
   logic [NM*EW-1:0]  west_o, west_oe, east_o, east_oe;
   logic [EW-1:0]     w_sel, woe_sel, e_sel, eoe_sel;
   logic [EW-1:0]     west_i = '0, east_i = '0;
   logic [NM*EW-1:0]  west_i_buf, east_i_buf;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   v_line_sw #(.NMACROS(NM), .EW_W(EW), .SEL_W(3), .BASE_ADR(CTRL), .BLANK_CYC(4)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
      .west_o(west_o), .west_oe(west_oe), .east_o(east_o), .east_oe(east_oe),
      .west_o_selected(w_sel), .west_oe_selected(woe_sel),
      .east_o_selected(e_sel), .east_oe_selected(eoe_sel),
      .west_i(west_i), .east_i(east_i),
      .west_i_buf(west_i_buf), .east_i_buf(east_i_buf)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // m = 0..2 selects macro m, anything else means all outputs tristated
   function automatic logic [63:0] exp_out(input int m);
      case (m)
         0:       return {8'h0, 14'h0123, 14'h00FF, 14'h1357, 14'h0001};
         1:       return {8'h0, 14'h1ABC, 14'h0F0F, 14'h2468, 14'h1111};
         2:       return {8'h0, 14'h2AAA, 14'h3FFF, 14'h0555, 14'h3C3C};
         default: return 64'h0;
      endcase
   endfunction

   task automatic chk_out(input string tag, input int m);
      chk(tag, {8'h0, w_sel, woe_sel, e_sel, eoe_sel}, exp_out(m));
   endtask

   // Called at a negedge; returns at a negedge after one idle cycle.
   task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] r);
      stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat = d; sel = s;
      @(posedge clk);
      @(negedge clk);
      chk("wb_ack", 64'(ack), 64'h1);
      r = dat_o;
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      @(negedge clk);
   endtask

   task automatic wb_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] r;
      wb_xfer(1'b1, a, d, s, r);
   endtask

   task automatic wb_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] r;
      wb_xfer(1'b0, a, 32'h0, 4'hF, r);
      chk(tag, 64'(r), 64'(exp));
   endtask

   initial begin
      west_o  = {14'h2AAA, 14'h1ABC, 14'h0123};
      west_oe = {14'h3FFF, 14'h0F0F, 14'h00FF};
      east_o  = {14'h0555, 14'h2468, 14'h1357};
      east_oe = {14'h3C3C, 14'h1111, 14'h0001};
      repeat (3) @(negedge clk);
      chk_out("out_in_reset", 3);
      rst = 1'b0;
      @(negedge clk);
      chk_out("out_after_reset", 3);
      chk("ack_reset", 64'(ack), 64'h0);
      chk("dat_reset", 64'(dat_o), 64'h0);

      west_i = 14'h2D4B; east_i = 14'h05A5;
      #1;
      chk("west_i_buf", 64'(west_i_buf), 64'({3{14'h2D4B}}));
      chk("east_i_buf", 64'(east_i_buf), 64'({3{14'h05A5}}));
      @(negedge clk);

      wb_rd("status_reset", STAT, 32'h0);
      wb_rd("ctrl_reset", CTRL, 32'h0);

      // unmatched address is never acked
      stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = CTRL + 32'd8;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("ack_unmatched", 64'(ack), 64'h0);
      end
      // held strobe: ack pulses 1,0,1
      adr = STAT;
      @(negedge clk); chk("held_ack0", 64'(ack), 64'h1);
      @(negedge clk); chk("held_ack1", 64'(ack), 64'h0);
      chk("held_dat_idle", 64'(dat_o), 64'h0);
      @(negedge clk); chk("held_ack2", 64'(ack), 64'h1);
      stb = 1'b0; cyc = 1'b0;
      @(negedge clk);

      // enable macro 1: four blanked cycles, then macro 1 on the cycle after ACTIVE
      wb_wr(CTRL, 32'h8000_0001, 4'hF);
      for (int i = 0; i < 4; i++) begin
         chk_out("blank_to_m1", 3);
         @(negedge clk);
      end
      chk_out("active_m1", 1);
      wb_rd("status_m1", STAT, 32'h0000_0001);
      wb_rd("ctrl_m1", CTRL, 32'h8000_0001);

      west_o[EW +: EW] = 14'h0777;
      @(negedge clk);
      chk("latency_1cyc", 64'(w_sel), 64'h0777);
      west_o[EW +: EW] = 14'h1ABC;
      @(negedge clk);

      // second change two cycles later reloads the blank counter
      wb_wr(CTRL, 32'h8000_0002, 4'hF);
      wb_wr(CTRL, 32'h8000_0000, 4'hF);
      for (int i = 0; i < 4; i++) begin
         chk_out("reload_blank", 3);
         @(negedge clk);
      end
      chk_out("active_m0", 0);
      wb_rd("status_m0", STAT, 32'h0000_0000);

      // busy visible in STATUS while blanking
      wb_wr(CTRL, 32'h8000_0001, 4'hF);
      wb_rd("status_busy_a", STAT, 32'h0000_0100);
      wb_rd("status_busy_b", STAT, 32'h0000_0100);
      wb_rd("status_busy_done", STAT, 32'h0000_0001);
      chk_out("active_m1_again", 1);

      // out-of-range select: ignored, err set, no transition
      wb_wr(CTRL, 32'h8000_0005, 4'hF);
      wb_rd("status_err", STAT, 32'h0000_0201);
      chk_out("no_switch_on_bad_sel", 1);
      wb_wr(STAT, 32'h0000_0200, 4'h1);
      wb_rd("err_kept_wrong_sel", STAT, 32'h0000_0201);
      wb_wr(STAT, 32'h0000_0200, 4'h2);
      wb_rd("err_cleared", STAT, 32'h0000_0001);

      // reset during an ack cycle
      stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = STAT; sel = 4'hF;
      @(posedge clk);
      #1;
      chk("pre_rst_ack", 64'(ack), 64'h1);
      chk("pre_rst_dat", 64'(dat_o), 64'h0000_0001);
      chk_out("pre_rst_out", 1);
      rst = 1'b1;
      #1;
      chk("rst_ack", 64'(ack), 64'h0);
      chk("rst_dat", 64'(dat_o), 64'h0);
      chk_out("rst_out", 3);
      @(negedge clk);
      stb = 1'b0; cyc = 1'b0; rst = 1'b0;
      @(negedge clk);
      wb_rd("status_after_rst", STAT, 32'h0);
      wb_rd("ctrl_after_rst", CTRL, 32'h0);
      repeat (6) @(negedge clk);
      chk_out("off_after_rst", 3);

      // reset in the middle of BLANK
      wb_wr(CTRL, 32'h8000_0001, 4'hF);
      rst = 1'b1;
      #1;
      chk_out("rst_blank_out", 3);
      chk("rst_blank_ack", 64'(ack), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      chk_out("off_after_blank_rst", 3);
      wb_rd("status_blank_rst", STAT, 32'h0);
      wb_rd("ctrl_blank_rst", CTRL, 32'h0);

      // byte select 0 only: select applied, enable untouched -> OFF with new act_sel
      wb_wr(CTRL, 32'h8000_0002, 4'h1);
      repeat (6) @(negedge clk);
      wb_rd("status_bytesel", STAT, 32'h0000_0002);
      wb_rd("ctrl_bytesel", CTRL, 32'h0000_0002);
      chk_out("off_bytesel", 3);

      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      wb_wr(CTRL, 32'hC000_0002, 4'hF);
      wb_wr(CTRL, 32'h8000_0000, 4'hF);
      repeat (8) @(negedge clk);
`ifdef V_LINE_SW_LOCK_EN
      wb_rd("status_lock", STAT, 32'h0000_0602);
      wb_rd("ctrl_lock", CTRL, 32'hC000_0002);
      chk_out("out_lock", 2);
`else
      wb_rd("status_nolock", STAT, 32'h0000_0000);
      wb_rd("ctrl_nolock", CTRL, 32'h8000_0000);
      chk_out("out_nolock", 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
